// File: rtl/fir_feeder_pkg.sv
// Shared types and constants for the FIR stream feeder.
package fir_feeder_pkg;

  localparam int unsigned ADDR_SHIFT    = 2;   // word index to byte address
  localparam int unsigned DEF_ADDR_W    = 12;
  localparam int unsigned DEF_DATA_W    = 32;
  localparam int unsigned DEF_BUF_DEPTH = 2;
  localparam int unsigned CNT_W         = 32;  // len, read index and stall counter width

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // One prefetched sample plus its end-of-block tag.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  last;
  } buf_ent_t;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fir_ss_feeder_if.sv
// AXI-Stream style sample bus between the feeder and the FIR ss port.
interface fir_ss_feeder_if #(
  parameter int unsigned DATA_W = 32
) ();

  logic              ss_tvalid;
  logic [DATA_W-1:0] ss_tdata;
  logic              ss_tlast;
  logic              ss_tready;

  modport master (
    output ss_tvalid,
    output ss_tdata,
    output ss_tlast,
    input  ss_tready
  );

  modport slave (
    input  ss_tvalid,
    input  ss_tdata,
    input  ss_tlast,
    output ss_tready
  );

endinterface

// File: rtl/fir_feeder_buf.sv
// Small prefetch FIFO of {data, last}. Entries shift toward slot 0 so the
// head is always a flop, keeping the stream outputs glitch-free and stable.
// Push into a full buffer is accepted when a pop happens on the same edge.
module fir_feeder_buf
  import fir_feeder_pkg::*;
#(
  parameter  int unsigned pBUF_DEPTH = DEF_BUF_DEPTH,
  localparam int unsigned OCC_W      = occ_width(pBUF_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  buf_ent_t         push_ent,
  input  logic             pop,
  output buf_ent_t         head,
  output logic             empty,
  output logic             full,
  output logic [OCC_W-1:0] occ
);

  buf_ent_t                ent_q [pBUF_DEPTH];
  buf_ent_t                ent_d [pBUF_DEPTH];
  logic [pBUF_DEPTH-1:0]   vld_q;
  logic [pBUF_DEPTH-1:0]   vld_d;
  logic [OCC_W-1:0]        occ_q;
  logic [OCC_W-1:0]        occ_d;
  logic [OCC_W-1:0]        wr_idx;
  logic                    pop_ok;
  logic                    push_ok;

  assign pop_ok  = pop & vld_q[0];
  assign push_ok = push & (~vld_q[pBUF_DEPTH-1] | pop_ok);

  // Next-state: shift out on pop, then write the new entry behind the survivors.
  always_comb begin
    ent_d  = ent_q;
    vld_d  = vld_q;
    wr_idx = occ_q - OCC_W'(pop_ok);
    occ_d  = occ_q + OCC_W'(push_ok) - OCC_W'(pop_ok);
    if (pop_ok) begin
      for (int i = 0; i < int'(pBUF_DEPTH) - 1; i++) begin
        ent_d[i] = ent_q[i+1];
        vld_d[i] = vld_q[i+1];
      end
      vld_d[pBUF_DEPTH-1] = 1'b0;
    end
    if (push_ok) begin
      for (int i = 0; i < int'(pBUF_DEPTH); i++) begin
        if (OCC_W'(i) == wr_idx) begin
          ent_d[i] = push_ent;
          vld_d[i] = 1'b1;
        end
      end
    end
  end

  // Storage, valid flags and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(pBUF_DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      vld_q <= '0;
      occ_q <= '0;
    end else begin
      ent_q <= ent_d;
      vld_q <= vld_d;
      occ_q <= occ_d;
    end
  end

  assign head  = ent_q[0];
  assign empty = ~vld_q[0];
  assign full  = vld_q[pBUF_DEPTH-1];
  assign occ   = occ_q;

endmodule

// File: rtl/fir_ss_feeder.sv
// Streams a block of samples from the sample BRAM onto the FIR ss port.
// Build option: FIR_SS_FEEDER_PERF_CNT_EN enables the backpressure stall
// counter; without it stall_cnt reads 0 and no counter exists.
// mem_EN/mem_A are decoded from registered state in the issue cycle so a read
// lands in the buffer one edge after the BRAM samples it; this keeps the
// in-flight window to one entry and lets a 2-deep buffer run at 1 beat/clock.
module fir_ss_feeder
  import fir_feeder_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned pDATA_WIDTH = DEF_DATA_W,
  parameter int unsigned pBUF_DEPTH  = DEF_BUF_DEPTH
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       len,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_EN,
  output logic [pADDR_WIDTH-1:0] mem_A,
  input  logic [pDATA_WIDTH-1:0] mem_Do,
  fir_ss_feeder_if.master        ss,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int unsigned OCC_W = occ_width(pBUF_DEPTH);

  state_e           state_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] rd_idx_q;
  logic             rd_pend_q;
  logic             last_pend_q;

  buf_ent_t         push_ent;
  buf_ent_t         head;
  logic             buf_empty;
  logic             buf_full;
  logic [OCC_W-1:0] buf_occ;

  logic             pop;
  logic             start_ok;
  logic [CNT_W-1:0] fill;
  logic             room;
  logic             rd_en;
  logic             rd_is_last;

  assign pop      = ~buf_empty & ss.ss_tready;
  assign start_ok = start & ~busy;

  // Space check counts buffered entries plus the read now on mem_Do, less any beat leaving.
  assign fill       = CNT_W'(buf_occ) + CNT_W'(rd_pend_q) - CNT_W'(pop);
  assign room       = (fill < CNT_W'(pBUF_DEPTH)) & ~(buf_full & ~pop);
  assign rd_en      = (state_q == RUN) & (rd_idx_q < len_q) & room;
  assign rd_is_last = (rd_idx_q == len_q - CNT_W'(1));

  assign mem_EN = rd_en;
  assign mem_A  = rd_en ? pADDR_WIDTH'(rd_idx_q << ADDR_SHIFT) : '0;

  assign push_ent.data = DEF_DATA_W'(mem_Do);
  assign push_ent.last = last_pend_q;

  fir_feeder_buf #(
    .pBUF_DEPTH (pBUF_DEPTH)
  ) u_buf (
    .clk      (axis_clk),
    .rst_n    (axis_rst_n),
    .push     (rd_pend_q),
    .push_ent (push_ent),
    .pop      (pop),
    .head     (head),
    .empty    (buf_empty),
    .full     (buf_full),
    .occ      (buf_occ)
  );

  assign ss.ss_tvalid = ~buf_empty;
  assign ss.ss_tdata  = pDATA_WIDTH'(head.data);
  assign ss.ss_tlast  = head.last;

  // Control FSM, read index and the one-deep read pipeline tracking.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rd_idx_q    <= '0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      rd_pend_q   <= rd_en;
      last_pend_q <= rd_en & rd_is_last;
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            if (len != '0) begin
              len_q    <= len;
              rd_idx_q <= '0;
              busy     <= 1'b1;
              done     <= 1'b0;
              state_q  <= RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_en) begin
            rd_idx_q <= rd_idx_q + CNT_W'(1);
          end
          if (pop & head.last) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef FIR_SS_FEEDER_PERF_CNT_EN
  // Saturating count of cycles the FIR holds off a valid beat.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      stall_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt <= '0;
    end else if (~buf_empty & ~ss.ss_tready & (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_ss_feeder.sv
// Bench for fir_ss_feeder: BRAM stub, ready pattern generator, a queue-based
// model of the expected block, and one negedge compare process.
module tb_fir_ss_feeder;

  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 1024;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n;
  logic          start;
  logic [31:0]   len;
  logic          busy;
  logic          done;
  logic          mem_EN;
  logic [AW-1:0] mem_A;
  logic [DW-1:0] mem_Do;
  logic [31:0]   stall_cnt;

  fir_ss_feeder_if #(.DATA_W(DW)) ss_bus ();

  fir_ss_feeder #(
    .pADDR_WIDTH (AW),
    .pDATA_WIDTH (DW),
    .pBUF_DEPTH  (2)
  ) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .start      (start),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .mem_EN     (mem_EN),
    .mem_A      (mem_A),
    .mem_Do     (mem_Do),
    .ss         (ss_bus.master),
    .stall_cnt  (stall_cnt)
  );

  always #5 axis_clk = ~axis_clk;

  // Sample BRAM: registered read, one cycle latency.
  logic [31:0] bram [WORDS];
  always @(posedge axis_clk) begin
    if (mem_EN) mem_Do <= bram[mem_A[AW-1:2]];
  end

  // Ready patterns: 0 = always, 1 = one cycle in three, 2 = random.
  int rdy_mode = 0;
  int rdy_ph   = 0;
  always @(posedge axis_clk) begin
    #1;
    case (rdy_mode)
      1: begin
        ss_bus.ss_tready = (rdy_ph == 0);
        rdy_ph = (rdy_ph == 2) ? 0 : rdy_ph + 1;
      end
      2:       ss_bus.ss_tready = 1'($urandom_range(0, 1));
      default: ss_bus.ss_tready = 1'b1;
    endcase
  end

  int n_checks = 0;
  int n_err    = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q [$];
  bit          exp_busy = 0;
  bit          exp_done = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  bit          first_seen = 1;
  int          beats = 0;
  int          tlast_cnt = 0;
  logic [31:0] first_data = '0;
  logic [31:0] last_data = '0;
  int          last_hs_cyc = 0;
  int          bench_stalls = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Model update and per-cycle comparison, sampled mid-cycle.
  always @(negedge axis_clk) begin
    beat_t e;
    bit    accepted;
    cyc++;
    if (!axis_rst_n) begin
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_mem_en", 32'(mem_EN), 32'd0);
      check("rst_mem_a", 32'(mem_A), 32'd0);
      check("rst_tvalid", 32'(ss_bus.ss_tvalid), 32'd0);
      check("rst_tdata", ss_bus.ss_tdata, 32'd0);
      check("rst_tlast", 32'(ss_bus.ss_tlast), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      exp_q.delete();
      exp_busy     = 0;
      exp_done     = 0;
      prev_stall   = 0;
      first_seen   = 1;
      bench_stalls = 0;
    end else begin
      accepted = start && !exp_busy;
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      if (prev_stall) begin
        check("hold_tvalid", 32'(ss_bus.ss_tvalid), 32'd1);
        check("hold_tdata", ss_bus.ss_tdata, prev_data);
        check("hold_tlast", 32'(ss_bus.ss_tlast), 32'(prev_last));
      end
      if (exp_q.size() == 0) check("idle_tvalid", 32'(ss_bus.ss_tvalid), 32'd0);
      if (ss_bus.ss_tvalid && !first_seen) begin
        first_seen = 1;
        check("latency", 32'(cyc - start_cyc), 32'd3);
      end
      if (ss_bus.ss_tvalid && ss_bus.ss_tready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("beat_tdata", ss_bus.ss_tdata, e.data);
        check("beat_tlast", 32'(ss_bus.ss_tlast), 32'(e.last));
        beats++;
        if (ss_bus.ss_tlast) tlast_cnt++;
        if (beats == 1) first_data = ss_bus.ss_tdata;
        last_data   = ss_bus.ss_tdata;
        last_hs_cyc = cyc;
        if (e.last) begin
          exp_busy = 0;
          exp_done = 1;
        end
      end
      if (ss_bus.ss_tvalid && !ss_bus.ss_tready) bench_stalls++;
      prev_stall = ss_bus.ss_tvalid && !ss_bus.ss_tready;
      prev_data  = ss_bus.ss_tdata;
      prev_last  = ss_bus.ss_tlast;
      if (accepted) begin
        bench_stalls = 0;
        beats        = 0;
        tlast_cnt    = 0;
        start_cyc    = cyc;
        if (len != 0) begin
          first_seen = 0;
          exp_busy   = 1;
          exp_done   = 0;
          for (int k = 0; k < int'(len); k++) begin
            exp_q.push_back('{data: bram[k % WORDS], last: (k == int'(len) - 1)});
          end
        end else begin
          exp_done   = 1;
          first_seen = 1;
        end
      end
    end
  end

  task automatic do_start(input logic [31:0] l);
    @(posedge axis_clk); #1;
    start = 1'b1;
    len   = l;
    @(posedge axis_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 0;
    for (int n = 0; n < max_cyc; n++) begin
      @(posedge axis_clk); #1;
      if (done && !busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("wait_done_timeout", 32'(done), 32'd1);
      check("wait_exp_empty", 32'(exp_q.size()), 32'd0);
    end
  endtask

  task automatic chk_stall(input string name);
`ifdef FIR_SS_FEEDER_PERF_CNT_EN
    check(name, stall_cnt, 32'(bench_stalls));
`else
    check(name, stall_cnt, 32'd0);
`endif
  endtask

  task automatic chk_block(input string name, input int n, input logic [31:0] fd, input logic [31:0] ld);
    check({name, "_beats"}, 32'(beats), 32'(n));
    check({name, "_tlast_cnt"}, 32'(tlast_cnt), 32'd1);
    check({name, "_first"}, first_data, fd);
    check({name, "_last"}, last_data, ld);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rl;
    bit          got10;
    axis_rst_n = 1'b0;
    start      = 1'b0;
    len        = '0;
    mem_Do     = '0;
    ss_bus.ss_tready = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) bram[i] = 32'(i);
    repeat (3) @(posedge axis_clk);
    #1 axis_rst_n = 1'b1;
    repeat (2) @(posedge axis_clk);

    // Full block, ready always high.
    rdy_mode = 0;
    do_start(32'd600);
    wait_idle(2000);
    chk_block("t1", 600, 32'd0, 32'd599);
    check("t1_no_bubbles", 32'(last_hs_cyc - start_cyc), 32'd602);
    chk_stall("t1_stall_cnt");

    // Same block, ready one cycle in three.
    rdy_mode = 1;
    rdy_ph   = 0;
    do_start(32'd600);
    wait_idle(4000);
    chk_block("t2", 600, 32'd0, 32'd599);
    chk_stall("t2_stall_cnt");
`ifdef FIR_SS_FEEDER_PERF_CNT_EN
    check("t2_stall_range", 32'((stall_cnt >= 32'd1194) && (stall_cnt <= 32'd1202)), 32'd1);
`endif

    // Zero-length start.
    rdy_mode = 0;
    do_start(32'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge axis_clk);
    #1 check("len0_beats", 32'(beats), 32'd0);

    // Reset after ten beats, then a short block from address 0.
    do_start(32'd600);
    got10 = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge axis_clk); #1;
      if (beats >= 10) begin
        got10 = 1;
        break;
      end
    end
    if (!got10) check("wait_beats", 32'(beats), 32'd10);
    axis_rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_mem_en", 32'(mem_EN), 32'd0);
    check("async_rst_tvalid", 32'(ss_bus.ss_tvalid), 32'd0);
    check("async_rst_tdata", ss_bus.ss_tdata, 32'd0);
    repeat (2) @(posedge axis_clk);
    #1 axis_rst_n = 1'b1;
    do_start(32'd5);
    wait_idle(100);
    chk_block("t5", 5, 32'd0, 32'd4);

    // Start pulse during a transfer is ignored.
    do_start(32'd600);
    repeat (50) @(posedge axis_clk);
    #1 start = 1'b1;
    len = 32'd3;
    @(posedge axis_clk);
    #1 start = 1'b0;
    wait_idle(2000);
    chk_block("t6", 600, 32'd0, 32'd599);

    // Single negative sample.
    bram[0] = 32'hFFFF_FFF6;
    do_start(32'd1);
    wait_idle(50);
    chk_block("t3", 1, 32'hFFFF_FFF6, 32'hFFFF_FFF6);

    // Random data, lengths and backpressure; the last block wraps the address space.
    rdy_mode = 2;
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < int'(WORDS); i++) bram[i] = $urandom;
      rl = (t == 4) ? 32'd1030 : 32'($urandom_range(1, 40));
      do_start(rl);
      wait_idle(int'(rl) * 40 + 50);
      check("rnd_beats", 32'(beats), rl);
      check("rnd_tlast_cnt", 32'(tlast_cnt), 32'd1);
      chk_stall("rnd_stall_cnt");
    end

    repeat (3) @(posedge axis_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
